// File: rtl/mlow_stim_pkg.sv
// ---------------------------------------------------------------------------
// mlow_stim_pkg
// Shared types and constants for the mlow_codec frame stimulus generator:
//   pattern_e      - sample pattern selector encoding
//   stim_state_e   - generator FSM state encoding
//   LFSR_POLY      - 16-bit LFSR polynomial mask
//   LFSR_SEED_DEFAULT - default LFSR reset/load value
//   lfsr_step()    - one LFSR advance
// ---------------------------------------------------------------------------
package mlow_stim_pkg;

    typedef enum logic [1:0] {
        PAT_RAMP  = 2'd0,
        PAT_CONST = 2'd1,
        PAT_LFSR  = 2'd2,
        PAT_ALT   = 2'd3
    } pattern_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_SGAP = 3'd2,
        ST_FGAP = 3'd3,
        ST_DONE = 3'd4
    } stim_state_e;

    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // Right-shifting register on the x^16+x^14+x^13+x^11+1 polynomial. The
    // feedback taps are LFSR_POLY bit-mirrored onto the low end of the
    // register, which gives ACE1 -> 5670 -> AB38 -> 559C from the default seed.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] taps;
        for (int i = 0; i < 16; i++) begin
            taps[i] = LFSR_POLY[15-i];
        end
        return {^(s & taps), s[15:1]};
    endfunction

endpackage

// File: rtl/mlow_pkt_monitor.sv
// ---------------------------------------------------------------------------
// mlow_pkt_monitor
// Passive framing checker for the codec packet bus.
//   clk_i, reset_i        - clock, asynchronous active-high reset
//   clear_i               - clears packet count and sticky error (run start)
//   packet_valid_i/ready_i- handshake; only completed beats are examined
//   packet_start_i/end_i  - framing markers
//   packets_seen_o        - wrapping count of end beats
//   protocol_error_o      - sticky start/end framing error
// ---------------------------------------------------------------------------
module mlow_pkt_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             packet_valid_i,
    input  logic             packet_ready_i,
    input  logic             packet_start_i,
    input  logic             packet_end_i,
    output logic [CNT_W-1:0] packets_seen_o,
    output logic             protocol_error_o
);

    logic in_pkt;
    logic beat;
    logic bad;

    assign beat = packet_valid_i && packet_ready_i;
    // A start+end beat is a complete one-beat packet, so an end with start
    // on the same beat is legal even outside a packet.
    assign bad  = (packet_start_i && in_pkt) ||
                  (packet_end_i && !in_pkt && !packet_start_i);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            in_pkt           <= 1'b0;
            packets_seen_o   <= '0;
            protocol_error_o <= 1'b0;
        end else begin
            if (beat) begin
                if (packet_start_i)    in_pkt <= !packet_end_i;
                else if (packet_end_i) in_pkt <= 1'b0;
            end
            if (clear_i) begin
                packets_seen_o   <= '0;
                protocol_error_o <= 1'b0;
            end else begin
                if (beat && packet_end_i) packets_seen_o   <= packets_seen_o + 1'b1;
                if (beat && bad)          protocol_error_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mlow_frame_stim_gen.sv
// ---------------------------------------------------------------------------
// mlow_frame_stim_gen
// Frame-structured multi-channel audio stimulus source for mlow_codec, with a
// packet-framing monitor on the codec output.
//   clk_i, reset_i         - clock, asynchronous active-high reset
//   start_i, abort_i       - run control
//   pattern_sel_i, base_value_i, num_frames_i, sample_gap_i, frame_gap_i
//                          - run configuration, latched on start
//   audio_*                - registered valid/ready sample stream to the codec
//   packet_*_i             - codec packet bus, observed only
//   busy_o, done_o         - run status
//   frames_sent_o, packets_seen_o, protocol_error_o - run statistics
// ---------------------------------------------------------------------------
module mlow_frame_stim_gen
    import mlow_stim_pkg::*;
#(
    parameter int          DATA_WIDTH   = 16,
    parameter int          FRAME_SIZE   = 16,
    parameter int          NUM_CHANNELS = 1,
    parameter int          CNT_W        = 8,
    parameter int          GAP_W        = 8,
    parameter logic [15:0] LFSR_SEED    = LFSR_SEED_DEFAULT,
    localparam int         CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [1:0]            pattern_sel_i,
    input  logic [DATA_WIDTH-1:0] base_value_i,
    input  logic [CNT_W-1:0]      num_frames_i,
    input  logic [GAP_W-1:0]      sample_gap_i,
    input  logic [GAP_W-1:0]      frame_gap_i,
    output logic [DATA_WIDTH-1:0] audio_data_o,
    output logic [CH_W-1:0]       audio_channel_o,
    output logic                  audio_valid_o,
    input  logic                  audio_ready_i,
    output logic                  audio_last_o,
    input  logic                  packet_valid_i,
    input  logic                  packet_ready_i,
    input  logic                  packet_start_i,
    input  logic                  packet_end_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_W-1:0]      frames_sent_o,
    output logic [CNT_W-1:0]      packets_seen_o,
    output logic                  protocol_error_o
);

    localparam int              SLOT_W    = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CHANNELS - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_SIZE - 1);

    function automatic logic [DATA_WIDTH-1:0] pattern_value(
        input pattern_e              p,
        input logic [DATA_WIDTH-1:0] base,
        input logic [DATA_WIDTH-1:0] g,
        input logic [15:0]           lf,
        input logic [CH_W-1:0]       c
    );
        logic [DATA_WIDTH-1:0]    cx;
        logic [DATA_WIDTH+15:0]   lx;
        logic [DATA_WIDTH-1:0]    result;
        cx = DATA_WIDTH'(c);
        lx = {{DATA_WIDTH{1'b0}}, lf};
        case (p)
            PAT_RAMP:  result = base + g + cx;
            PAT_CONST: result = base + cx;
            PAT_LFSR:  result = lx[DATA_WIDTH-1:0] + cx;
            default:   result = g[0] ? ((-base) + cx) : (base + cx);
        endcase
        return result;
    endfunction

    stim_state_e           state;
    pattern_e              cfg_pat;
    logic [DATA_WIDTH-1:0] cfg_base;
    logic [CNT_W-1:0]      cfg_frames;
    logic [GAP_W-1:0]      cfg_sgap;
    logic [GAP_W-1:0]      cfg_fgap;
    logic [GAP_W-1:0]      gap_cnt;
    logic [SLOT_W-1:0]     slot;
    logic [CH_W-1:0]       chan;
    logic [DATA_WIDTH-1:0] g;
    logic [15:0]           lfsr;

    logic                  fire;
    logic                  last_chan;
    logic                  last_slot;
    logic [CNT_W-1:0]      frames_inc;
    logic [SLOT_W-1:0]     slot_nxt;
    logic [CH_W-1:0]       chan_nxt;
    logic [DATA_WIDTH-1:0] g_nxt;
    logic [15:0]           lfsr_nxt;
    logic [DATA_WIDTH-1:0] beat_data;
    logic                  beat_last;
    logic [DATA_WIDTH-1:0] start_data;
    logic                  start_accept;

    assign start_accept = (state == ST_IDLE) && start_i;
    assign fire         = (state == ST_SEND) && audio_valid_o && audio_ready_i;
    assign last_chan    = (chan == LAST_CH);
    assign last_slot    = (slot == LAST_SLOT);
    assign frames_inc   = frames_sent_o + 1'b1;
    assign busy_o       = (state == ST_SEND) || (state == ST_SGAP) || (state == ST_FGAP);
    assign done_o       = (state == ST_DONE);

    // Position of the beat that follows the current one. Outside a completed
    // beat it is the current position, which is what a gap exit presents.
    always_comb begin
        chan_nxt = chan;
        slot_nxt = slot;
        g_nxt    = g;
        lfsr_nxt = lfsr;
        if (fire) begin
            if (last_chan) begin
                chan_nxt = '0;
                slot_nxt = last_slot ? '0 : slot + 1'b1;
                g_nxt    = g + 1'b1;
                lfsr_nxt = lfsr_step(lfsr);
            end else begin
                chan_nxt = chan + 1'b1;
            end
        end
    end

    assign beat_data  = pattern_value(cfg_pat, cfg_base, g_nxt, lfsr_nxt, chan_nxt);
    assign beat_last  = (chan_nxt == LAST_CH) && (slot_nxt == LAST_SLOT);
    assign start_data = pattern_value(pattern_e'(pattern_sel_i), base_value_i, '0, LFSR_SEED, '0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state           <= ST_IDLE;
            cfg_pat         <= PAT_RAMP;
            cfg_base        <= '0;
            cfg_frames      <= '0;
            cfg_sgap        <= '0;
            cfg_fgap        <= '0;
            gap_cnt         <= '0;
            slot            <= '0;
            chan            <= '0;
            g               <= '0;
            lfsr            <= LFSR_SEED;
            frames_sent_o   <= '0;
            audio_data_o    <= '0;
            audio_channel_o <= '0;
            audio_valid_o   <= 1'b0;
            audio_last_o    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        cfg_pat         <= pattern_e'(pattern_sel_i);
                        cfg_base        <= base_value_i;
                        cfg_frames      <= num_frames_i;
                        cfg_sgap        <= sample_gap_i;
                        cfg_fgap        <= frame_gap_i;
                        gap_cnt         <= '0;
                        slot            <= '0;
                        chan            <= '0;
                        g               <= '0;
                        lfsr            <= LFSR_SEED;
                        frames_sent_o   <= '0;
                        state           <= ST_SEND;
                        audio_valid_o   <= 1'b1;
                        audio_data_o    <= start_data;
                        audio_channel_o <= '0;
                        audio_last_o    <= (LAST_CH == '0) && (LAST_SLOT == '0);
                    end
                end
                ST_SEND: begin
                    if (fire) begin
                        chan <= chan_nxt;
                        slot <= slot_nxt;
                        g    <= g_nxt;
                        lfsr <= lfsr_nxt;
                        if (last_chan && last_slot) frames_sent_o <= frames_inc;
                        // Abort is only honoured once the pending beat is taken.
                        if (abort_i) begin
                            state         <= ST_IDLE;
                            audio_valid_o <= 1'b0;
                        end else if (last_chan && last_slot &&
                                     cfg_frames != '0 && frames_inc == cfg_frames) begin
                            state         <= ST_DONE;
                            audio_valid_o <= 1'b0;
                        end else if (last_chan && last_slot && cfg_fgap != '0) begin
                            state         <= ST_FGAP;
                            gap_cnt       <= cfg_fgap;
                            audio_valid_o <= 1'b0;
                        end else if (last_chan && !last_slot && cfg_sgap != '0) begin
                            state         <= ST_SGAP;
                            gap_cnt       <= cfg_sgap;
                            audio_valid_o <= 1'b0;
                        end else begin
                            audio_data_o    <= beat_data;
                            audio_channel_o <= chan_nxt;
                            audio_last_o    <= beat_last;
                        end
                    end
                end
                ST_SGAP, ST_FGAP: begin
                    // gap_cnt counts the idle cycles still to spend, including this one.
                    if (abort_i) begin
                        state <= ST_IDLE;
                    end else if (gap_cnt <= GAP_W'(1)) begin
                        state           <= ST_SEND;
                        audio_valid_o   <= 1'b1;
                        audio_data_o    <= beat_data;
                        audio_channel_o <= chan_nxt;
                        audio_last_o    <= beat_last;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    mlow_pkt_monitor #(
        .CNT_W (CNT_W)
    ) u_pkt_monitor (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .clear_i          (start_accept),
        .packet_valid_i   (packet_valid_i),
        .packet_ready_i   (packet_ready_i),
        .packet_start_i   (packet_start_i),
        .packet_end_i     (packet_end_i),
        .packets_seen_o   (packets_seen_o),
        .protocol_error_o (protocol_error_o)
    );

endmodule

// File: tb/tb_mlow_frame_stim_gen.sv
module tb_mlow_frame_stim_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start2, abort, ready, ready2;
    logic        pv, pr, ps, pe;
    logic [1:0]  pat;
    logic [15:0] base;
    logic [7:0]  nfr, sgap, fgap;

    // single-channel instance
    logic [15:0] a_data;
    logic [0:0]  a_ch;
    logic        a_valid, a_last, busy, done, perr;
    logic [7:0]  frames, pkts;

    // two-channel instance
    logic [15:0] b_data;
    logic [0:0]  b_ch;
    logic        b_valid, b_last, b_busy, b_done, b_perr;
    logic [7:0]  b_frames, b_pkts;

    int checks   = 0;
    int failures = 0;
    int k, b, low;
    logic got;
    logic [15:0] lfsr_exp [4] = '{16'hACE1, 16'h5670, 16'hAB38, 16'h559C};

    mlow_frame_stim_gen #(.NUM_CHANNELS(1)) dut (
        .clk_i(clk), .reset_i(rst), .start_i(start), .abort_i(abort),
        .pattern_sel_i(pat), .base_value_i(base), .num_frames_i(nfr),
        .sample_gap_i(sgap), .frame_gap_i(fgap),
        .audio_data_o(a_data), .audio_channel_o(a_ch), .audio_valid_o(a_valid),
        .audio_ready_i(ready), .audio_last_o(a_last),
        .packet_valid_i(pv), .packet_ready_i(pr), .packet_start_i(ps), .packet_end_i(pe),
        .busy_o(busy), .done_o(done), .frames_sent_o(frames),
        .packets_seen_o(pkts), .protocol_error_o(perr)
    );

    mlow_frame_stim_gen #(.NUM_CHANNELS(2)) dut2 (
        .clk_i(clk), .reset_i(rst), .start_i(start2), .abort_i(abort),
        .pattern_sel_i(pat), .base_value_i(base), .num_frames_i(nfr),
        .sample_gap_i(sgap), .frame_gap_i(fgap),
        .audio_data_o(b_data), .audio_channel_o(b_ch), .audio_valid_o(b_valid),
        .audio_ready_i(ready2), .audio_last_o(b_last),
        .packet_valid_i(pv), .packet_ready_i(pr), .packet_start_i(ps), .packet_end_i(pe),
        .busy_o(b_busy), .done_o(b_done), .frames_sent_o(b_frames),
        .packets_seen_o(b_pkts), .protocol_error_o(b_perr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_data"},   32'(a_data),  32'h0);
        chk({tag, "_ch"},     32'(a_ch),    32'h0);
        chk({tag, "_valid"},  32'(a_valid), 32'h0);
        chk({tag, "_last"},   32'(a_last),  32'h0);
        chk({tag, "_busy"},   32'(busy),    32'h0);
        chk({tag, "_done"},   32'(done),    32'h0);
        chk({tag, "_frames"}, 32'(frames),  32'h0);
        chk({tag, "_pkts"},   32'(pkts),    32'h0);
        chk({tag, "_perr"},   32'(perr),    32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0; abort = 1'b0;
        ready = 1'b0; ready2 = 1'b0;
        pv = 1'b0; pr = 1'b0; ps = 1'b0; pe = 1'b0;
        pat = 2'd0; base = 16'h0; nfr = 8'd0; sgap = 8'd0; fgap = 8'd0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_b_valid", 32'(b_valid), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Ramp: 2 frames x 16 slots, no gaps, ready high
        pat = 2'd0; base = 16'h1234; nfr = 8'd2; ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ramp_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 32; i++) begin
            chk("ramp_valid", 32'(a_valid), 32'h1);
            chk("ramp_data",  32'(a_data),  32'h1234 + 32'(i));
            chk("ramp_last",  32'(a_last),  32'((i == 15) || (i == 31)));
            @(negedge clk);
        end
        chk("ramp_done",   32'(done),    32'h1);
        chk("ramp_busy_lo", 32'(busy),   32'h0);
        chk("ramp_frames", 32'(frames),  32'h2);
        chk("ramp_valid_lo", 32'(a_valid), 32'h0);
        @(negedge clk);
        chk("ramp_done_pulse", 32'(done), 32'h0);

        // Backpressure: 2 channels, ready toggling every cycle
        pat = 2'd0; base = 16'h0100; nfr = 8'd1; start2 = 1'b1; ready2 = 1'b0;
        @(negedge clk);
        start2 = 1'b0;
        k = 0; got = 1'b0;
        for (int cyc = 0; cyc < 200 && !got; cyc++) begin
            ready2 = (cyc % 2 == 1);
            if (b_done) begin
                got = 1'b1;
            end else if (b_valid) begin
                chk("bp_data", 32'(b_data), 32'h100 + 32'(k / 2) + 32'(k % 2));
                chk("bp_ch",   32'(b_ch),   32'(k % 2));
                chk("bp_last", 32'(b_last), 32'(k == 31));
                if (ready2) k++;
            end
            if (!got) @(negedge clk);
        end
        ready2 = 1'b0;
        chk("bp_done_seen", 32'(got), 32'h1);
        chk("bp_beats",  32'(k), 32'd32);
        chk("bp_frames", 32'(b_frames), 32'h1);
        chk("bp_busy",   32'(b_busy), 32'h0);
        @(negedge clk);

        // Gaps: sample gap 3, frame gap 10
        pat = 2'd0; base = 16'h0000; nfr = 8'd2; sgap = 8'd3; fgap = 8'd10;
        ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b = 0; low = 0; got = 1'b0;
        for (int cyc = 0; cyc < 600 && !got; cyc++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (a_valid) begin
                    if (b > 0) chk("gap_len", 32'(low), (b == 16) ? 32'd10 : 32'd3);
                    chk("gap_data", 32'(a_data), 32'(b));
                    b++;
                    low = 0;
                end else begin
                    low++;
                end
                @(negedge clk);
            end
        end
        chk("gap_done_seen", 32'(got), 32'h1);
        chk("gap_beats", 32'(b), 32'd32);
        sgap = 8'd0; fgap = 8'd0;
        @(negedge clk);

        // LFSR run, continuous, then reset mid-run
        pat = 2'd2; base = 16'h0000; nfr = 8'd0; ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("lfsr1_valid", 32'(a_valid), 32'h1);
            chk("lfsr1_data",  32'(a_data),  32'(lfsr_exp[i]));
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk_idle_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Restart must replay the same sequence; then abort during a stall
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("lfsr2_data", 32'(a_data), 32'(lfsr_exp[i]));
            if (i == 3) ready = 1'b0;
            @(negedge clk);
        end
        chk("abort_stall_valid", 32'(a_valid), 32'h1);
        chk("abort_stall_data",  32'(a_data),  32'h559C);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_hold_valid", 32'(a_valid), 32'h1);
        chk("abort_hold_data",  32'(a_data),  32'h559C);
        chk("abort_hold_busy",  32'(busy),    32'h1);
        ready = 1'b1;
        @(negedge clk);
        chk("abort_valid", 32'(a_valid), 32'h0);
        chk("abort_busy",  32'(busy),    32'h0);
        chk("abort_done",  32'(done),    32'h0);
        abort = 1'b0;
        @(negedge clk);
        chk("abort_done_after", 32'(done), 32'h0);
        chk("abort_busy_after", 32'(busy), 32'h0);

        // Packet monitor: start, end, start+end, then an unaccepted beat
        pv = 1'b1; pr = 1'b1; ps = 1'b1; pe = 1'b0;
        @(negedge clk);
        chk("pkt_start_err", 32'(perr), 32'h0);
        ps = 1'b0; pe = 1'b1;
        @(negedge clk);
        chk("pkt_end_cnt", 32'(pkts), 32'h1);
        ps = 1'b1; pe = 1'b1;
        @(negedge clk);
        pr = 1'b0;
        @(negedge clk);
        pv = 1'b0; ps = 1'b0; pe = 1'b0;
        chk("pkt_count", 32'(pkts), 32'h2);
        chk("pkt_no_err", 32'(perr), 32'h0);

        // Double start raises the sticky error
        pv = 1'b1; pr = 1'b1; ps = 1'b1;
        @(negedge clk);
        chk("pkt_first_start", 32'(perr), 32'h0);
        @(negedge clk);
        pv = 1'b0; pr = 1'b0; ps = 1'b0;
        chk("pkt_dbl_start_err", 32'(perr), 32'h1);
        repeat (3) @(negedge clk);
        chk("pkt_err_sticky", 32'(perr), 32'h1);
        chk("pkt_count_kept", 32'(pkts), 32'h2);

        // Next start clears the monitor; constant pattern run of one frame
        pat = 2'd1; base = 16'h00AA; nfr = 8'd1; ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("clr_err",  32'(perr), 32'h0);
        chk("clr_pkts", 32'(pkts), 32'h0);
        got = 1'b0;
        for (int cyc = 0; cyc < 100 && !got; cyc++) begin
            if (done) got = 1'b1;
            else begin
                if (a_valid) chk("const_data", 32'(a_data), 32'h00AA);
                @(negedge clk);
            end
        end
        chk("const_done_seen", 32'(got), 32'h1);
        chk("const_frames", 32'(frames), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
